// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pooling-mode encodings, default sample width and pooled-dimension helper
package cnn_pkg;
    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;
    localparam int DEF_DATA_W = 12;
    function automatic int pooled_dim(input int w);
        return w / 2;
    endfunction
endpackage

// File: rtl/pool_relu_stream_if.sv
// pool_relu_stream_if: pixel stream into and pooled stream out of the pool/ReLU stage
//   valid_in/in_data/pool_mode : upstream conv stage -> pool stage
//   out_data/valid_out/frame_done : pool stage -> downstream stage (always accepts)
interface pool_relu_stream_if import cnn_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = 3
);
    logic                     valid_in;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     pool_mode;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     valid_out;
    logic                     frame_done;
    modport master (output valid_in, in_data, pool_mode, input out_data, valid_out, frame_done);
    modport slave (input valid_in, in_data, pool_mode, output out_data, valid_out, frame_done);
endinterface

// File: rtl/pool_lane.sv
// pool_lane: one channel of 2x2 pooling -- horizontal pair, line buffer, vertical combine, ReLU
//   clk  : rising-edge clock
//   hold : capture x as the left sample of a horizontal pair (even column)
//   we   : store the horizontal result in the line buffer (even row, odd column)
//   mode : 0 = max, 1 = average
//   widx : line-buffer entry (col >> 1)
//   x    : signed input sample
//   r    : combinational pooled result, valid on an odd-row/odd-column input
module pool_lane import cnn_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 12,
    parameter int IW      = 4,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              hold,
    input  logic              we,
    input  logic              mode,
    input  logic [IW-1:0]     widx,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] r
);
    logic signed [DATA_W-1:0] xs, h_reg_q, h_reg_d;
    logic signed [DATA_W:0]   h, b, pmax;
    logic signed [DATA_W+1:0] sum;
    logic        [DATA_W-1:0] r_pre;
    logic signed [DATA_W:0]   lb_q [DEPTH];

    always_comb begin
        xs      = x;
        h_reg_d = hold ? xs : h_reg_q;
        h       = (mode == POOL_AVG) ? (DATA_W+1)'(h_reg_q) + (DATA_W+1)'(xs)
                                     : (h_reg_q > xs ? (DATA_W+1)'(h_reg_q) : (DATA_W+1)'(xs));
        b       = lb_q[widx];
        sum     = (DATA_W+2)'(b) + (DATA_W+2)'(h);
        pmax    = (b > h) ? b : h;
        // Arithmetic shift floors toward -inf; the quarter of a 4-sample sum always fits DATA_W.
        r_pre   = (mode == POOL_AVG) ? DATA_W'(sum >>> 2) : DATA_W'(pmax);
        r       = (RELU_EN != 0 && r_pre[DATA_W-1]) ? '0 : r_pre;
    end

    // Line-buffer entries are always written on the even row before the odd row reads them.
    always_ff @(posedge clk) begin
        h_reg_q <= h_reg_d;
        if (we) lb_q[widx] <= h;
    end
endmodule

// File: rtl/pool_relu_stream.sv
// pool_relu_stream: 2x2/stride-2 max/avg pooling with optional ReLU over NUM_CH lockstep channels
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of pool_relu_stream_if (raster pixel stream in, pooled stream out)
module pool_relu_stream import cnn_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = 3,
    parameter int IN_W    = 24,
    parameter int IN_H    = 24,
    parameter int RELU_EN = 1
) (
    input logic               clk,
    input logic               rst,
    pool_relu_stream_if.slave bus
);
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic                     mode_q, mode_d;
    logic [NUM_CH*DATA_W-1:0] out_q, out_d, r_all;
    logic                     valid_q, valid_d, done_q, done_d;
    logic                     last_col, last_row, fire;

    always_comb begin
        last_col = col_q == CW'(IN_W - 1);
        last_row = row_q == RW'(IN_H - 1);
        fire     = bus.valid_in && col_q[0] && row_q[0];
        col_d    = bus.valid_in ? (last_col ? '0 : col_q + 1'b1) : col_q;
        row_d    = (bus.valid_in && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
        // Mode is latched only at the first pixel so a frame is pooled uniformly.
        mode_d   = (bus.valid_in && col_q == '0 && row_q == '0) ? bus.pool_mode : mode_q;
        out_d    = fire ? r_all : out_q;
        valid_d  = fire;
        done_d   = fire && last_col && last_row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= POOL_MAX;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        pool_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (pooled_dim(IN_W)),
            .IW     (CW - 1),
            .RELU_EN(RELU_EN)
        ) u_lane (
            .clk (clk),
            .hold(bus.valid_in && !col_q[0]),
            .we  (bus.valid_in && col_q[0] && !row_q[0]),
            .mode(mode_q),
            .widx(col_q[CW-1:1]),
            .x   (bus.in_data[g*DATA_W +: DATA_W]),
            .r   (r_all[g*DATA_W +: DATA_W])
        );
    end

    assign bus.out_data   = out_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_pool_relu_stream.sv
// tb_pool_relu_stream: randomized scoreboard bench for pool_relu_stream (ReLU on and off instances)
module tb_pool_relu_stream;
    localparam int DW = 12, NC = 2, W = 4, H = 4;

    typedef struct packed {
        logic [NC*DW-1:0] d;
        logic             fd;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic valid_in = 1'b0, pool_mode = 1'b0;
    logic [NC*DW-1:0] in_data = '0;
    always #5 clk = ~clk;

    pool_relu_stream_if #(.DATA_W(DW), .NUM_CH(NC)) bus0 (), bus1 ();
    assign bus0.valid_in = valid_in;
    assign bus0.in_data = in_data;
    assign bus0.pool_mode = pool_mode;
    assign bus1.valid_in = valid_in;
    assign bus1.in_data = in_data;
    assign bus1.pool_mode = pool_mode;

    pool_relu_stream #(.DATA_W(DW), .NUM_CH(NC), .IN_W(W), .IN_H(H), .RELU_EN(0))
        u_raw (.clk(clk), .rst(rst), .bus(bus0));
    pool_relu_stream #(.DATA_W(DW), .NUM_CH(NC), .IN_W(W), .IN_H(H), .RELU_EN(1))
        u_relu (.clk(clk), .rst(rst), .bus(bus1));

    exp_t q0[$], q1[$];
    int   cap[$];
    int   errors = 0, checks = 0;
    int   fr[H][W][NC];
    int   n = 0, exp_done = 0;
    int   nout[2] = '{0, 0}, ndone[2] = '{0, 0};
    logic fmode = 1'b0;

    function automatic int fdiv4(input int s);
        return (s - (((s % 4) + 4) % 4)) / 4;
    endfunction

    task automatic chk(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // Reference: pool the 2x2 window ending at (c,r) straight from the stored frame.
    task automatic push_exp(input int r, input int c);
        exp_t e0, e1;
        int   a, b, x, y, v, mv;
        e0.d = '0;
        e1.d = '0;
        for (int ch = 0; ch < NC; ch++) begin
            a = fr[r-1][c-1][ch]; b = fr[r-1][c][ch]; x = fr[r][c-1][ch]; y = fr[r][c][ch];
            mv = a;
            if (b > mv) mv = b;
            if (x > mv) mv = x;
            if (y > mv) mv = y;
            v = fmode ? fdiv4(a + b + x + y) : mv;
            e0.d[ch*DW +: DW] = DW'(v);
            e1.d[ch*DW +: DW] = DW'(v < 0 ? 0 : v);
        end
        e0.fd = (r == H - 1) && (c == W - 1);
        e1.fd = e0.fd;
        if (e0.fd) exp_done++;
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic send(input int c0, input int c1, input logic m, input int gap_pct);
        int r, c;
        while ($urandom_range(99) < gap_pct) begin
            @(negedge clk);
            valid_in = 1'b0;
            in_data = (NC*DW)'($urandom);
            pool_mode = 1'($urandom);
        end
        @(negedge clk);
        valid_in = 1'b1;
        in_data = {DW'(c1), DW'(c0)};
        pool_mode = m;
        r = n / W;
        c = n % W;
        if (n == 0) fmode = m;
        fr[r][c][0] = c0;
        fr[r][c][1] = c1;
        if ((r % 2 == 1) && (c % 2 == 1)) push_exp(r, c);
        n = (n + 1) % (W * H);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    // kind 0: ramp on ch0; 1: random; 2: negative window {-4,-8,-2,-6} at the first 2x2 block.
    task automatic frame(input int kind, input logic m, input int gap, input bit toggle);
        int c0, c1;
        logic mm;
        for (int i = 0; i < W * H; i++) begin
            c0 = rnd();
            c1 = rnd();
            if (kind == 0) begin
                c0 = i;
                c1 = -i;
            end
            if (kind == 2) begin
                if (i == 0) c0 = -4;
                if (i == 1) c0 = -8;
                if (i == W) c0 = -2;
                if (i == W + 1) c0 = -6;
            end
            mm = (i == 0 || !toggle) ? m : 1'($urandom);
            send(c0, c1, mm, gap);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [NC*DW-1:0] d, input logic fd);
        exp_t e;
        if (v) begin
            nout[k]++;
            if (fd) ndone[k]++;
            if (k == 1) cap.push_back(int'($signed(d[DW-1:0])));
            checks++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_out dut%0d: got data=%h done=%b, required no output", k, d, fd);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if ({d, fd} !== {e.d, e.fd}) begin
                    errors++;
                    $display("FAIL pooled_out dut%0d: got data=%h done=%b, required data=%h done=%b",
                             k, d, fd, e.d, e.fd);
                end
            end
        end else if (fd) begin
            checks++;
            errors++;
            $display("FAIL stray_done dut%0d: got frame_done=1 with valid_out=0, required 0", k);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.valid_out, bus0.out_data, bus0.frame_done);
        mon(1, bus1.valid_out, bus1.out_data, bus1.frame_done);
    end

    task automatic reset_check(input string nm);
        chk({nm, "_valid0"}, int'(bus0.valid_out), 0);
        chk({nm, "_done0"}, int'(bus0.frame_done), 0);
        chk({nm, "_data0"}, int'(bus0.out_data), 0);
        chk({nm, "_data1"}, int'(bus1.out_data), 0);
        chk({nm, "_valid1"}, int'(bus1.valid_out), 0);
    endtask

    task automatic ramp_check(input string nm, input int e0, input int e1, input int e2, input int e3);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        chk({nm, "_count"}, cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++) chk(nm, cap[i], ev[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst = 1'b0;

        cap.delete();
        frame(0, 1'b0, 0, 1'b0);
        idle(2);
        ramp_check("ramp_max", 5, 7, 13, 15);

        cap.delete();
        frame(0, 1'b1, 0, 1'b0);
        idle(2);
        ramp_check("ramp_avg", 2, 4, 10, 12);

        frame(2, 1'b0, 0, 1'b0);
        frame(2, 1'b1, 0, 1'b0);
        idle(2);

        frame(1, 1'b0, 0, 1'b1);
        frame(1, 1'b1, 0, 1'b0);
        idle(1);

        for (int f = 0; f < 8; f++) frame(1, 1'($urandom), 50, 1'b1);
        idle(2);

        for (int i = 0; i < W * 2 + 2; i++) send(rnd(), rnd(), 1'b1, 30);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        reset_check("midframe_reset");
        rst = 1'b0;
        n = 0;
        frame(1, 1'b0, 50, 1'b0);
        frame(2, 1'b1, 50, 1'b1);
        idle(3);

        chk("queue0_left", q0.size(), 0);
        chk("queue1_left", q1.size(), 0);
        chk("done_count0", ndone[0], exp_done);
        chk("done_count1", ndone[1], exp_done);
        chk("valid_count0", nout[0], nout[1]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
